decode_stage_pipelined: RTL

Parametrised instruction-decode stage with its own ID/EX output register and valid/ready handshake. It sits between the IF/ID register and the execute stage. It contains the register file with write-first bypass from writeback, the main control decoder, the hazard bubble/flush logic, and BEQ/BNE/J resolution. Redirects are registered: one pulse per resolved branch or jump.

---
 rtl/decode_stage_pipelined.sv | 107 ++++++++++
 1 files changed

// File: rtl/decode_stage_pipelined.sv
// decode_stage_pipelined: ID stage with regfile, control decode, branch resolution and ID/EX register
module decode_stage_pipelined #(
  parameter int DATA_W = 32,
  parameter int PC_W = 10,
  parameter int RA_W = 5
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [PC_W-1:0]   in_pc_plus4,
  input  logic [31:0]       in_instr,
  input  logic              wb_reg_write,
  input  logic [RA_W-1:0]   wb_addr,
  input  logic [DATA_W-1:0] wb_data,
  input  logic              data_hazard,
  input  logic              flush,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_reg1,
  output logic [DATA_W-1:0] out_reg2,
  output logic [DATA_W-1:0] out_imm,
  output logic [RA_W-1:0]   out_dest,
  output logic              out_mem_to_reg,
  output logic              out_mem_read,
  output logic              out_mem_write,
  output logic              out_alu_src,
  output logic              out_reg_write,
  output logic [1:0]        out_alu_op,
  output logic              redirect_valid,
  output logic [PC_W-1:0]   redirect_pc
);
  logic [DATA_W-1:0] rf [2**RA_W];
  logic [5:0] op;
  logic [RA_W-1:0] rs, rt, rd;
  logic [DATA_W-1:0] rd1, rd2, imm;
  logic [PC_W-1:0] br_tgt, j_tgt;
  logic is_r, is_lw, is_sw, is_addi, is_beq, is_bne, is_j;
  logic adv, acc, load, taken, redir;
  assign op = in_instr[31:26];
  assign rs = in_instr[21 +: RA_W];
  assign rt = in_instr[16 +: RA_W];
  assign rd = in_instr[11 +: RA_W];
  assign is_r = op == 6'h00;
  assign is_lw = op == 6'h23;
  assign is_sw = op == 6'h2B;
  assign is_addi = op == 6'h08;
  assign is_beq = op == 6'h04;
  assign is_bne = op == 6'h05;
  assign is_j = op == 6'h02;
  // same-cycle writeback wins over the stored value so the consumer never sees a stale operand
  assign rd1 = rs == '0 ? '0 : (wb_reg_write && wb_addr == rs) ? wb_data : rf[rs];
  assign rd2 = rt == '0 ? '0 : (wb_reg_write && wb_addr == rt) ? wb_data : rf[rt];
  assign imm = {{(DATA_W-16){in_instr[15]}}, in_instr[15:0]};
  assign br_tgt = in_pc_plus4 + {imm[PC_W-3:0], 2'b00};
  assign j_tgt = {in_instr[PC_W-3:0], 2'b00};
  assign adv = ~out_valid | out_ready;
  // a flushed instruction is still consumed from IF/ID, so flush masks the load-use stall
  assign in_ready = reset & (flush | ~data_hazard) & adv;
  assign acc = in_valid & in_ready;
  assign load = acc & ~flush;
  assign taken = (is_beq & (rd1 == rd2)) | (is_bne & (rd1 != rd2));
  assign redir = load & (taken | is_j);
  // register file write port; reset clears every entry
  always_ff @(posedge clk) begin
    if (!reset)
      for (int i = 0; i < 2**RA_W; i++) rf[i] <= '0;
    else if (wb_reg_write && wb_addr != '0)
      rf[wb_addr] <= wb_data;
  end
  // ID/EX register and one-cycle redirect pulse
  always_ff @(posedge clk) begin
    if (!reset) begin
      out_valid <= 1'b0;
      out_reg1 <= '0;
      out_reg2 <= '0;
      out_imm <= '0;
      out_dest <= '0;
      out_mem_to_reg <= 1'b0;
      out_mem_read <= 1'b0;
      out_mem_write <= 1'b0;
      out_alu_src <= 1'b0;
      out_reg_write <= 1'b0;
      out_alu_op <= 2'b00;
      redirect_valid <= 1'b0;
      redirect_pc <= '0;
    end else begin
      redirect_valid <= redir;
      if (redir) redirect_pc <= is_j ? j_tgt : br_tgt;
      if (adv) begin
        out_valid <= load;
        if (load) begin
          out_reg1 <= rd1;
          out_reg2 <= rd2;
          out_imm <= imm;
          out_dest <= is_r ? rd : rt;
          out_mem_to_reg <= is_lw;
          out_mem_read <= is_lw;
          out_mem_write <= is_sw;
          out_alu_src <= is_lw | is_sw | is_addi;
          out_reg_write <= is_r | is_lw | is_addi;
          out_alu_op <= is_r ? 2'b10 : (is_beq | is_bne) ? 2'b01 : 2'b00;
        end
      end
    end
  end
endmodule
